// File: rtl/lsu_arb_pkg.sv
// Shared definitions for the two-port LSU arbiter: FSM states, address map
// and the legal byte-mask encodings.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [15:0] DMEM_BASE  = 16'h2000;
  localparam logic [15:0] DMEM_LIMIT = 16'h3FFF;
  localparam logic [15:0] OUT_BASE   = 16'h7000;
  localparam logic [15:0] OUT_LIMIT  = 16'h703F;
  localparam logic [15:0] IN_BASE    = 16'h7800;
  localparam logic [15:0] IN_LIMIT   = 16'h781F;

  localparam logic [3:0] NB_BYTE = 4'b0001;
  localparam logic [3:0] NB_HALF = 4'b0011;
  localparam logic [3:0] NB_WORD = 4'b1111;

  function automatic logic in_region(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational legality check for one access: region, byte mask,
// alignment and write protection of the IN region.
module lsu_addr_check
  import lsu_arb_pkg::*;
(
  input  logic [15:0] addr,
  input  logic [3:0]  num_byte,
  input  logic        wren,
  output logic        illegal
);

  logic in_dmem, in_out, in_in;
  logic size_ok, misaligned;

  assign in_dmem = in_region(addr, DMEM_BASE, DMEM_LIMIT);
  assign in_out  = in_region(addr, OUT_BASE, OUT_LIMIT);
  assign in_in   = in_region(addr, IN_BASE, IN_LIMIT);

  assign size_ok    = (num_byte == NB_BYTE) || (num_byte == NB_HALF) || (num_byte == NB_WORD);
  assign misaligned = ((num_byte == NB_HALF) && addr[0]) ||
                      ((num_byte == NB_WORD) && (addr[1:0] != 2'b00));

  assign illegal = !(in_dmem || in_out || in_in) || !size_ok || misaligned ||
                   (wren && in_in);

endmodule

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one LSU between the CPU port (m0) and the
// debug/DMA port (m1); every access takes grant, access and response cycles.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting; grants one requesting port combinationally
//   ST_ACCESS | latched fields drive the LSU; load data captured at the end
//   ST_RESP   | rvalid/err/rdata presented on the granted port
module lsu_arbiter
  import lsu_arb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic        i_m0_ld_uns,
  input  logic [3:0]  i_m0_num_byte,
  input  logic [15:0] i_m0_addr,
  input  logic [31:0] i_m0_st_data,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rdata,

  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic        i_m1_ld_uns,
  input  logic [3:0]  i_m1_num_byte,
  input  logic [15:0] i_m1_addr,
  input  logic [31:0] i_m1_st_data,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rdata,

  output logic        o_lsu_wren,
  output logic        o_ld_uns,
  output logic [3:0]  o_num_byte,
  output logic [15:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  input  logic [31:0] i_ld_data
);

  state_t state, state_nx;
  logic   prio;  // port that wins a tie
  logic   grant, sel;

  logic        sel_wren, sel_ld_uns, sel_illegal;
  logic [3:0]  sel_num_byte;
  logic [15:0] sel_addr;
  logic [31:0] sel_st_data;

  logic        q_port, q_wren, q_ld_uns, q_illegal;
  logic [3:0]  q_num_byte;
  logic [15:0] q_addr;
  logic [31:0] q_st_data, q_rdata;

  logic in_access, in_resp, resp0, resp1;

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    sel      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!i_rst && (i_m0_req || i_m1_req)) begin
          grant    = 1'b1;
          sel      = (i_m0_req && i_m1_req) ? prio : i_m1_req;
          state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign sel_wren     = sel ? i_m1_wren     : i_m0_wren;
  assign sel_ld_uns   = sel ? i_m1_ld_uns   : i_m0_ld_uns;
  assign sel_num_byte = sel ? i_m1_num_byte : i_m0_num_byte;
  assign sel_addr     = sel ? i_m1_addr     : i_m0_addr;
  assign sel_st_data  = sel ? i_m1_st_data  : i_m0_st_data;

  lsu_addr_check u_addr_check (
    .addr     (sel_addr),
    .num_byte (sel_num_byte),
    .wren     (sel_wren),
    .illegal  (sel_illegal)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      q_port     <= 1'b0;
      q_wren     <= 1'b0;
      q_ld_uns   <= 1'b0;
      q_illegal  <= 1'b0;
      q_num_byte <= '0;
      q_addr     <= '0;
      q_st_data  <= '0;
      q_rdata    <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        prio       <= ~sel;
        q_port     <= sel;
        q_wren     <= sel_wren;
        q_ld_uns   <= sel_ld_uns;
        q_illegal  <= sel_illegal;
        q_num_byte <= sel_num_byte;
        q_addr     <= sel_addr;
        q_st_data  <= sel_st_data;
      end
      // stores and rejected accesses return zero data
      if (state == ST_ACCESS) q_rdata <= (q_wren || q_illegal) ? '0 : i_ld_data;
    end
  end

  assign in_access = (state == ST_ACCESS);
  assign in_resp   = (state == ST_RESP);

  assign o_m0_gnt = grant & ~sel;
  assign o_m1_gnt = grant & sel;

  assign o_lsu_wren = in_access & q_wren & ~q_illegal;
  assign o_ld_uns   = in_access & q_ld_uns;
  assign o_num_byte = in_access ? q_num_byte : '0;
  assign o_lsu_addr = in_access ? q_addr     : '0;
  assign o_st_data  = in_access ? q_st_data  : '0;

  assign resp0 = in_resp & ~q_port;
  assign resp1 = in_resp &  q_port;

  assign o_m0_rvalid = resp0;
  assign o_m0_err    = resp0 & q_illegal;
  assign o_m0_rdata  = resp0 ? q_rdata : '0;
  assign o_m1_rvalid = resp1;
  assign o_m1_err    = resp1 & q_illegal;
  assign o_m1_rdata  = resp1 ? q_rdata : '0;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: a byte-memory LSU stand-in plus a transaction-level
// reference model of legality, load extension and store effects.
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wren, m0_ld_uns, m1_req, m1_wren, m1_ld_uns;
  logic [3:0]  m0_num_byte, m1_num_byte;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_st_data, m1_st_data;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        lsu_wren, ld_uns;
  logic [3:0]  num_byte;
  logic [15:0] lsu_addr;
  logic [31:0] st_data, ld_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_ld_uns(m0_ld_uns),
    .i_m0_num_byte(m0_num_byte), .i_m0_addr(m0_addr), .i_m0_st_data(m0_st_data),
    .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_ld_uns(m1_ld_uns),
    .i_m1_num_byte(m1_num_byte), .i_m1_addr(m1_addr), .i_m1_st_data(m1_st_data),
    .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
    .o_lsu_wren(lsu_wren), .o_ld_uns(ld_uns), .o_num_byte(num_byte),
    .o_lsu_addr(lsu_addr), .o_st_data(st_data), .i_ld_data(ld_data)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] + 8'h3C);
  endfunction

  // LSU stand-in: byte memory, combinational extended read, write mid-cycle
  logic [7:0]  lsu_mem [0:65535];
  logic [31:0] raw_word;
  initial begin
    for (int i = 0; i < 65536; i++) lsu_mem[i] = init_byte(16'(i));
    forever begin
      @(negedge clk);
      if (lsu_wren)
        for (int i = 0; i < 4; i++)
          if (num_byte[i]) lsu_mem[16'(lsu_addr + 16'(i))] = st_data[8*i +: 8];
    end
  end

  always_comb begin
    raw_word = {lsu_mem[16'(lsu_addr + 16'd3)], lsu_mem[16'(lsu_addr + 16'd2)],
                lsu_mem[16'(lsu_addr + 16'd1)], lsu_mem[lsu_addr]};
    case (num_byte)
      4'b0001: ld_data = ld_uns ? {24'b0, raw_word[7:0]}  : {{24{raw_word[7]}}, raw_word[7:0]};
      4'b0011: ld_data = ld_uns ? {16'b0, raw_word[15:0]} : {{16{raw_word[15]}}, raw_word[15:0]};
      default: ld_data = raw_word;
    endcase
  end

  // Reference model: bytes written so far, everything else at its initial value
  logic [7:0] ref_wr [int];

  function automatic logic [7:0] ref_byte(input int a);
    if (ref_wr.exists(a)) return ref_wr[a];
    return init_byte(a[15:0]);
  endfunction

  function automatic int nb_bytes(input logic [3:0] nb);
    if (nb == 4'b0001) return 1;
    if (nb == 4'b0011) return 2;
    if (nb == 4'b1111) return 4;
    return 0;
  endfunction

  function automatic bit ref_legal(input logic [15:0] a, input logic [3:0] nb, input logic wr);
    int n  = nb_bytes(nb);
    int ai = int'(a);
    bit dm = (ai >= 'h2000) && (ai <= 'h3FFF);
    bit ou = (ai >= 'h7000) && (ai <= 'h703F);
    bit iv = (ai >= 'h7800) && (ai <= 'h781F);
    if (n == 0) return 1'b0;
    if ((ai % n) != 0) return 1'b0;
    if (!(dm || ou || iv)) return 1'b0;
    if (wr && iv) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [3:0] nb, input logic uns);
    int n = nb_bytes(nb);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_byte(int'(a) + i)) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic w, input logic u,
                         input logic [3:0] nb, input logic [15:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_req = r; m0_wren = w; m0_ld_uns = u; m0_num_byte = nb; m0_addr = a; m0_st_data = d;
    end else begin
      m1_req = r; m1_wren = w; m1_ld_uns = u; m1_num_byte = nb; m1_addr = a; m1_st_data = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One complete transaction on port p; entered and left just after a rising edge.
  task automatic do_txn(input int p, input logic w, input logic u, input logic [3:0] nb,
                        input logic [15:0] a, input logic [31:0] d);
    bit          legal = ref_legal(a, nb, w);
    logic [31:0] exp_rd = (!legal || w) ? 32'd0 : ref_load(a, nb, u);
    bit          got = 1'b0;
    set_req(p, 1'b1, w, u, nb, a, d);
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("gnt_seen", 32'(got), 32'd1);
    check("gnt_own", 32'(p ? m1_gnt : m0_gnt), 32'd1);
    check("gnt_other", 32'(p ? m0_gnt : m1_gnt), 32'd0);
    @(posedge clk);
    #1 set_req(p, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
    @(negedge clk);
    check("acc_wren", 32'(lsu_wren), 32'(legal && w));
    check("acc_addr", 32'(lsu_addr), 32'(a));
    check("acc_nb", 32'(num_byte), 32'(nb));
    if (legal && w) check("acc_stdata", st_data, d);
    check("acc_no_rvalid", 32'(m0_rvalid | m1_rvalid), 32'd0);
    @(negedge clk);
    check("resp_rvalid", 32'(p ? m1_rvalid : m0_rvalid), 32'd1);
    check("resp_other", 32'({m0_rvalid, m0_err, |m0_rdata} & {3{p == 1}}) |
                        32'({m1_rvalid, m1_err, |m1_rdata} & {3{p == 0}}), 32'd0);
    check("resp_err", 32'(p ? m1_err : m0_err), 32'(!legal));
    check("resp_rdata", p ? m1_rdata : m0_rdata, exp_rd);
    check("resp_lsu_idle", 32'({lsu_wren, lsu_addr}), 32'd0);
    if (legal && w)
      for (int i = 0; i < nb_bytes(nb); i++) ref_wr[int'(a) + i] = d[8*i +: 8];
    @(posedge clk);
    #1;
  endtask

  int          gport [4];
  int          gcyc  [4];
  int          ngr;
  logic [3:0]  r_nb;
  logic [15:0] r_a;
  int          n;

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    check("rst_resp", 32'({m0_rvalid, m0_err, m1_rvalid, m1_err}), 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    check("rst_lsu", 32'({lsu_wren, ld_uns, num_byte, lsu_addr}) | st_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_txn(0, 1'b1, 1'b0, 4'b1111, 16'h2004, 32'hDEADBEEF);
    do_txn(0, 1'b0, 1'b0, 4'b1111, 16'h2004, 32'd0);
    do_txn(1, 1'b1, 1'b0, 4'b1111, 16'h7800, 32'h12345678);
    do_txn(1, 1'b0, 1'b0, 4'b1111, 16'h2002, 32'd0);
    do_txn(0, 1'b1, 1'b0, 4'b0001, 16'h2001, 32'h00000080);
    do_txn(0, 1'b0, 1'b0, 4'b0001, 16'h2001, 32'd0);
    do_txn(0, 1'b0, 1'b1, 4'b0001, 16'h2001, 32'd0);
    do_txn(0, 1'b1, 1'b0, 4'b0111, 16'h7020, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++)
      check("hex0_kept", 32'(lsu_mem[16'h7020 + 16'(i)]), 32'(ref_byte('h7020 + i)));

    // both ports held: grants must alternate starting with m0, 3 cycles apart
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'b1111, 16'h2100, 32'd0);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'b1111, 16'h2200, 32'd0);
    ngr = 0;
    for (int cyc = 0; cyc < 30 && ngr < 4; cyc++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        check("rr_one_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
        gport[ngr] = m1_gnt ? 1 : 0;
        gcyc[ngr]  = cyc;
        ngr++;
      end
      @(posedge clk);
      #1;
    end
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
    check("rr_count", 32'(ngr), 32'd4);
    for (int i = 0; i < ngr; i++) begin
      check("rr_order", 32'(gport[i]), 32'(i % 2));
      if (i > 0) check("rr_interval", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
    repeat (3) @(posedge clk);
    #1;

    // reset during ACCESS of an m0 load aborts it and restores m0 priority
    set_req(0, 1'b1, 1'b0, 1'b0, 4'b1111, 16'h2004, 32'd0);
    @(negedge clk);
    check("abort_gnt", 32'(m0_gnt), 32'd1);
    @(posedge clk);
    #1 set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
      check("abort_lsu_idle", 32'(lsu_addr), 32'd0);
      @(posedge clk);
      #1;
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 4'b1111, 16'h2100, 32'd0);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'b1111, 16'h2200, 32'd0);
    @(negedge clk);
    check("abort_next_gnt", 32'({m0_gnt, m1_gnt}), 32'b10);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(7))
        0, 1:    r_nb = 4'b0001;
        2, 3:    r_nb = 4'b0011;
        4, 5, 6: r_nb = 4'b1111;
        default: r_nb = 4'($urandom);
      endcase
      case ($urandom_range(7))
        0, 1, 2, 3, 4: r_a = 16'h2000 + 16'($urandom_range(16'h1FFF));
        5:             r_a = 16'h7000 + 16'($urandom_range(16'h3F));
        6:             r_a = 16'h7800 + 16'($urandom_range(16'h1F));
        default:       r_a = 16'($urandom);
      endcase
      n = nb_bytes(r_nb);
      if (n > 0 && $urandom_range(1) == 1) r_a = r_a & ~(16'(n) - 16'd1);
      do_txn(int'($urandom_range(1)), 1'($urandom), 1'($urandom), r_nb, r_a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have no parameters; address map constants come from the shared package.
REQ-002 i_clk  in  1  single clock; all state changes on rising edge.
REQ-003 i_rst  in  1  reset; synchronous, active-high.
REQ-004 i_m0_req  in  1  port 0 (CPU) request; held with fields stable until o_m0_gnt.
REQ-005 i_m0_wren  in  1  port 0 store (1) / load (0).
REQ-006 i_m0_ld_uns  in  1  port 0 unsigned-load select.
REQ-007 i_m0_num_byte  in  4  port 0 byte mask; legal values 0001, 0011, 1111.
REQ-008 i_m0_addr  in  16  port 0 byte address.
REQ-009 i_m0_st_data  in  32  port 0 store data.
REQ-010 o_m0_gnt  out  1  one-cycle pulse; request accepted.
REQ-011 o_m0_rvalid  out  1  one-cycle completion pulse, for loads and stores.
REQ-012 o_m0_err  out  1  valid with o_m0_rvalid; access rejected.
REQ-013 o_m0_rdata  out  32  load data, valid with o_m0_rvalid; 0 for stores and errors.
REQ-014 Port 1 (debug/DMA) SHALL have the same ten ports with prefix i_m1_/o_m1_.
REQ-015 o_lsu_wren, o_ld_uns, o_num_byte[3:0], o_lsu_addr[15:0], o_st_data[31:0]  out  drive the LSU inputs of the same names.
REQ-016 i_ld_data  in  32  LSU o_ld_data; combinational from the presented address.

Function
REQ-017 FSM states are IDLE, ACCESS and RESP; IDLE->ACCESS on an accepted request, ACCESS->RESP always, RESP->IDLE always.
REQ-018 In IDLE with any req high, the arbiter SHALL assert gnt combinationally to exactly one port in that cycle (cycle N) and latch that port's fields and index.
REQ-019 Arbitration SHALL be round-robin: the port not served last wins when both request; after reset port 0 has priority.
REQ-020 No gnt SHALL be issued outside IDLE; a request held during ACCESS/RESP waits.
REQ-021 In ACCESS (cycle N+1), LSU outputs SHALL carry the latched fields and i_ld_data SHALL be registered at the end of that cycle.
REQ-022 o_lsu_wren SHALL be high only in ACCESS, only for a legal store, and for exactly one cycle.
REQ-023 In RESP (cycle N+2), rvalid/err/rdata SHALL be driven on the granted port only; the other port's outputs stay 0.
REQ-024 Minimum issue interval is 3 cycles; back-to-back requests from both ports alternate.
REQ-025 An access SHALL be illegal if the address lies outside DMEM 0x2000-0x3FFF, OUT 0x7000-0x703F and IN 0x7800-0x781F.
REQ-026 An access SHALL also be illegal if num_byte is not 0001, 0011 or 1111.
REQ-027 An access SHALL also be illegal if it is a halfword with addr[0]=1, a word with addr[1:0]!=00, or a store to the IN region.
REQ-028 An illegal access SHALL still be granted and complete in RESP with err=1 and rdata=0, with o_lsu_wren held 0.
REQ-029 In every state other than ACCESS, the LSU outputs SHALL be 0.

Reset
REQ-030 While i_rst is high at an edge: state IDLE, priority pointer to port 0, all outputs 0 from the next cycle.
REQ-031 Reset in ACCESS or RESP SHALL abort the transaction: no rvalid is issued, and a store still in ACCESS at the reset edge has been written at most once.

Structure
REQ-032 Package lsu_arb_pkg SHALL hold the state enum, the region base/limit constants and the legal num_byte constants.
REQ-033 Sub-module lsu_addr_check SHALL be combinational: (addr, num_byte, wren) -> illegal.
REQ-034 The RTL target size is 150-300 lines.

Verification
REQ-035 m0 store 0x2004, word 0xDEADBEEF, then m0 load 0x2004 -> gnt at N, wren pulse at N+1, rvalid at N+2, rdata=0xDEADBEEF, err=0.
REQ-036 m0 and m1 req in the same cycle, both held for 4 transactions -> grant order m0, m1, m0, m1, one gnt every 3 cycles.
REQ-037 m1 store word to 0x7800 -> err=1, o_lsu_wren never high; m1 word load 0x2002 -> err=1, rdata=0.
REQ-038 m0 byte load, ld_uns=0, at 0x2001 holding 0x80 -> rdata=0xFFFFFF80; with ld_uns=1 -> 0x00000080.
REQ-039 Assert i_rst during ACCESS of an m0 load -> no rvalid follows, state IDLE, next request granted to m0.
REQ-040 num_byte=0111 to 0x7020 -> err=1, HEX0 output unchanged.
